fifo_rr_arbiter: RTL
====================

Name: fifo_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that drains NUM_IN upstream FIFOs into one downstream FIFO, one word per cycle at most.
- Honours downstream almost-full back-pressure.
- Distributes almost-full/almost-empty thresholds to all FIFOs, loaded during an INIT phase.
- Folds FIFO error flags into a sticky ERROR state.
- Sits between the per-class input FIFOs and the shared output FIFO of the datapath.

Parameters:
- DATA_BITS, 10, FIFO word width.
- ADDR_BITS, 3, FIFO address width; threshold width.
- NUM_IN, 4, number of upstream FIFOs (fixed at 4 for this revision).
- HIGH_DEF, 6, reset value of the almost-full threshold.
- LOW_DEF, 1, reset value of the almost-empty threshold.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- init  in  1  high = load thresholds, hold arbitration.
- high_cfg  in  ADDR_BITS  almost-full threshold to load.
- low_cfg  in  ADDR_BITS  almost-empty threshold to load.
- in_empty  in  NUM_IN  upstream FIFO empty flags; bit i = FIFO i.
- in_data  in  NUM_IN*DATA_BITS  upstream read data; FIFO i at [i*DATA_BITS +: DATA_BITS].
- in_err  in  NUM_IN+1  error flags; bits 0..NUM_IN-1 = upstream FIFOs, bit NUM_IN = downstream FIFO.
- out_almost_full  in  1  downstream almost-full.
- in_pop  out  NUM_IN  read strobes to the upstream FIFOs, one-hot or zero.
- out_push  out  1  write strobe to the downstream FIFO.
- out_data  out  DATA_BITS  write data to the downstream FIFO.
- high_limit_out  out  ADDR_BITS  threshold driven to every FIFO's high_limit.
- low_limit_out  out  ADDR_BITS  threshold driven to every FIFO's low_limit.
- state_out  out  3  current state encoding.
- idle_out  out  1  high in IDLE.
- error_out  out  1  high in ERROR.

Behaviour:
- Reset (reset==0 at posedge):
  - state=RESET(000), rr_ptr=NUM_IN-1, out_push=0, out_data=0.
  - high_limit_out=HIGH_DEF, low_limit_out=LOW_DEF.
  - idle_out=0, error_out=0, sel_q=0.
  - in_pop is forced 0 while reset is low.
- States:
  - RESET=000, INIT=001, IDLE=010, ACTIVE=011, ERROR=100.
  - state_out mirrors the state register.
- Transitions, evaluated at each posedge with reset high, highest priority first:
  - Any non-RESET state with |in_err -> ERROR. ERROR is sticky; only reset exits it.
  - RESET -> INIT unconditionally.
  - INIT: while init=1, load high_cfg/low_cfg into the limit registers every cycle. When init=0 -> IDLE.
  - IDLE/ACTIVE with init=1 -> INIT.
  - IDLE -> ACTIVE when any in_empty bit is 0; ACTIVE -> IDLE when all in_empty bits are 1.
- Grant (combinational):
  - Enabled only in state ACTIVE with out_almost_full=0 and init=0 and no in_err bit set.
  - Selects the first i with in_empty[i]=0, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
  - in_pop[i]=1 for that i only. At most one pop per cycle.
- On a grant at posedge N: rr_ptr<=i, sel_q<=i, push_pending<=1.
- Read latency: an upstream FIFO presents the popped word on in_data in the cycle after the pop.
  - out_push=1 during cycle N+1 (registered).
  - out_data=in_data slice for sel_q, registered into out_data at N+1.
  - Total pop-to-push latency: 1 cycle. Sustained throughput: 1 word/cycle.
- Back-pressure:
  - out_almost_full=1 blocks new grants the same cycle.
  - A push already pending still completes, so the downstream high threshold must leave ≥1 slot of margin.
  - rr_ptr is unchanged while blocked; arbitration resumes at the next index with no skip.
- Entering ERROR or INIT:
  - No new pops.
  - An in-flight push (pop in the previous cycle) still completes exactly once.
- Reset mid-operation: a pending push is discarded, out_push=0, and all registers return to reset values.
- Threshold outputs change only in INIT or on reset.

Test Plan:
- Reset low 2 cycles, then init=1 with high_cfg=6, low_cfg=2 for 2 cycles, init=0 -> state_out 000→001→010; high_limit_out=6, low_limit_out=2; idle_out=1.
- In IDLE, in_empty=4'b1011 with FIFO2 data 10'h155 -> ACTIVE next cycle; in_pop=4'b0100 for one cycle; next cycle out_push=1, out_data=10'h155.
- All in_empty=0 continuously -> in_pop sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; out_push high every cycle from the second grant cycle on.
- During the RR stream after grant 1, assert out_almost_full for 3 cycles -> in_pop=0 during those cycles; the pending FIFO1 word is still pushed. After deassert, the first pop is 0100.
- In ACTIVE, pulse in_err[4] for 1 cycle -> state_out=100 and error_out=1 next cycle; in_pop stays 0 and ERROR holds until reset.
- In ACTIVE, raise init with high_cfg=5 -> state INIT next cycle; the last pop's push completes once; high_limit_out=5; arbitration resumes after init=0.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of NUM_IN upstream FIFOs into one downstream FIFO, with threshold
// distribution during INIT and a sticky ERROR state fed by the FIFO error flags.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_BITS = 10,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned HIGH_DEF  = 6,
    parameter int unsigned LOW_DEF   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [ADDR_BITS-1:0]        high_cfg,
    input  logic [ADDR_BITS-1:0]        low_cfg,
    input  logic [NUM_IN-1:0]           in_empty,
    input  logic [NUM_IN*DATA_BITS-1:0] in_data,
    input  logic [NUM_IN:0]             in_err,
    input  logic                        out_almost_full,
    output logic [NUM_IN-1:0]           in_pop,
    output logic                        out_push,
    output logic [DATA_BITS-1:0]        out_data,
    output logic [ADDR_BITS-1:0]        high_limit_out,
    output logic [ADDR_BITS-1:0]        low_limit_out,
    output logic [2:0]                  state_out,
    output logic                        idle_out,
    output logic                        error_out
);

    localparam int unsigned PTR_BITS = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [PTR_BITS-1:0] PtrLast = PTR_BITS'(NUM_IN - 1);

    localparam logic [2:0] StReset  = 3'b000;
    localparam logic [2:0] StInit   = 3'b001;
    localparam logic [2:0] StIdle   = 3'b010;
    localparam logic [2:0] StActive = 3'b011;
    localparam logic [2:0] StError  = 3'b100;

    logic [2:0]           state_q, state_d;
    logic [PTR_BITS-1:0]  rr_ptr_q, sel_q;
    logic                 push_pending_q;
    logic [ADDR_BITS-1:0] high_q, low_q;

    logic                 arb_en;
    logic                 gnt_valid;
    logic [PTR_BITS-1:0]  gnt_idx;
    logic [PTR_BITS-1:0]  cand;
    logic [DATA_BITS-1:0] in_words [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_words
        assign in_words[g] = in_data[g*DATA_BITS +: DATA_BITS];
    end

    // Search starts just after the last granted index so every FIFO gets a fair turn.
    always_comb begin
        arb_en    = (state_q == StActive) && !out_almost_full && !init && !(|in_err);
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(NUM_IN); k++) begin
            cand = PTR_BITS'((int'(rr_ptr_q) + k) % int'(NUM_IN));
            if (arb_en && !gnt_valid && !in_empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        in_pop = '0;
        if (reset && gnt_valid) begin
            in_pop[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != StReset && (|in_err)) begin
            state_d = StError;
        end else begin
            case (state_q)
                StReset:  state_d = StInit;
                StInit:   state_d = init ? StInit : StIdle;
                StIdle: begin
                    if (init)                state_d = StInit;
                    else if (!(&in_empty))   state_d = StActive;
                end
                StActive: begin
                    if (init)                state_d = StInit;
                    else if (&in_empty)      state_d = StIdle;
                end
                StError:  state_d = StError;
                default:  state_d = StError;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StReset;
            rr_ptr_q       <= PtrLast;
            sel_q          <= '0;
            push_pending_q <= 1'b0;
            high_q         <= ADDR_BITS'(HIGH_DEF);
            low_q          <= ADDR_BITS'(LOW_DEF);
        end else begin
            state_q        <= state_d;
            // A pop always completes its push next cycle, whatever the state does.
            push_pending_q <= gnt_valid;
            if (gnt_valid) begin
                rr_ptr_q <= gnt_idx;
                sel_q    <= gnt_idx;
            end
            if (state_q == StInit && init) begin
                high_q <= high_cfg;
                low_q  <= low_cfg;
            end
        end
    end

    // Popped word is on in_data in the cycle after the pop, alongside the registered push.
    assign out_push       = push_pending_q;
    assign out_data       = push_pending_q ? in_words[sel_q] : '0;
    assign high_limit_out = high_q;
    assign low_limit_out  = low_q;
    assign state_out      = state_q;
    assign idle_out       = (state_q == StIdle);
    assign error_out      = (state_q == StError);

endmodule
